noc_rr_arbiter: RTL
===================

// Module: noc_rr_arbiter
// PURPOSE
//  Parametrised per-output crossbar arbiter for the NoC router.
//  Each output port independently picks one input port: request-aware round-robin
//  (default) or fixed TDM rotation (legacy mode). In round-robin mode a winner keeps
//  the output until its tail flit transfers (wormhole lock).
//  Sits between the route-compute stage and the crossbar mux select.
// PARAMETERS
//  NPORTS       5  number of router ports (inputs = outputs); index 0..NPORTS-1
//  ALLOW_UTURN  0  1: input o may be granted output o; 0: input o never wins output o
//  MODE_TDM     0  1: fixed rotating slots, requests/tails ignored; 0: round-robin + lock
// PORTS
//  clk          in   1               clock
//  rst          in   1               reset, synchronous, active-high
//  req_i        in   NPORTS*NPORTS   req_i[o*NPORTS+i]: input i has flit for output o
//  tail_i       in   NPORTS          tail_i[i]: current flit at input i is a tail flit
//  out_ready_i  in   NPORTS          out_ready_i[o]: downstream of output o accepts a flit
//  grant_o      out  NPORTS*NPORTS   grant_o[o*NPORTS+i]: input i owns output o (registered)
//  busy_o       out  NPORTS          busy_o[o]: output o is locked to an owner
// BEHAVIOUR
//  Reset: grant_o=0, busy_o=0, every output IDLE, ptr[o]=o
//   (TDM: slot[o]=(o+1)%NPORTS, skipping o if !ALLOW_UTURN).
//  Per output o, grant_o[o*NPORTS +: NPORTS] is all-zero or one-hot; never more than one bit.
//  Eligible(i,o) = req_i[o*NPORTS+i] && (ALLOW_UTURN || i!=o).
//  Round-robin mode, per-output FSM IDLE/LOCKED:
//   IDLE: winner = first eligible i scanning ptr+1, ptr+2, ... mod NPORTS.
//     If any eligible -> next cycle LOCKED, owner=winner, grant bit and busy_o[o] set.
//     Otherwise stay IDLE. out_ready_i does not gate acquisition.
//   LOCKED: transfer = req_i[o*NPORTS+owner] && out_ready_i[o].
//     transfer && tail_i[owner] -> next cycle IDLE, grant/busy clear, ptr[o]=owner.
//     Owner's req low (abort) -> next cycle IDLE, ptr[o]=owner.
//     Else hold owner; other requests wait. No preemption.
//   Arbitration latency 1 cycle (request at N -> grant at N+1).
//   Single-flit packet (head=tail): acquire N+1, transfer+tail N+1, IDLE at N+2.
//   Re-arbitration from IDLE needs one idle cycle; back-to-back grants to the same
//   output are at best every other cycle for single-flit packets.
//   Outputs arbitrate independently. An input requesting several outputs may win
//   several; route compute guarantees at most one request per input.
//  TDM mode: busy_o=0 always; grant_o[o] = onehot(slot[o]) every cycle regardless
//   of req/tail/ready.
//   slot[o] advances by 1 mod NPORTS each cycle, skipping o when !ALLOW_UTURN.
//   Period NPORTS-1 (no U-turn) or NPORTS.
//  Reset mid-operation: all locks drop, the next cycle shows reset values, and
//   pointers reload. No flit state is kept.
//  NPORTS >= 2. Pointer width is $clog2(NPORTS). Wrap from NPORTS-1 to 0 is explicit
//   (no reliance on power-of-2 overflow).
// TESTING
//  1. Reset, NPORTS=5, no requests -> grant_o=0, busy_o=0 for 10 cycles.
//  2. Out 2: inputs 0,1,3 request single-flit (tail=1, ready=1) continuously
//     -> owners 3,0,1,3,... (each grant 1 cycle, IDLE gap between).
//  3. Input 4 sends 4-flit packet to out 1, ready toggles 1,0,1,1,0,1; input 0 also
//     requests -> input 4 holds grant until tail accepted; input 0 granted the cycle
//     after IDLE.
//  4. ALLOW_UTURN=0: input 3 requests only out 3 -> no grant ever.
//     ALLOW_UTURN=1: grant at N+1.
//  5. MODE_TDM=1, NPORTS=5, no U-turn -> out 0 slot sequence 1,2,3,4,1,...;
//     grants independent of req.
//  6. Assert rst while out 2 LOCKED to input 4 -> next cycle grant_o=0, busy_o=0;
//     after release ptr[2]=2, so input 3 beats input 4.

Source files
------------

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
//
// Per-output crossbar arbiter for the NoC router. It sits between route compute
// and the crossbar mux select. Every output port picks one input port on its
// own, in one of two modes:
//   * Round-robin (MODE_TDM = 0): a request-aware rotating priority scan. The
//     winner keeps the output until its tail flit transfers or it drops its
//     request. This is the wormhole lock.
//   * TDM (MODE_TDM = 1): the legacy mode. A fixed slot rotates once per cycle
//     and ignores requests, tails and ready.
//
// Parameters
//   NPORTS       number of router ports (inputs = outputs), must be >= 2
//   ALLOW_UTURN  1: input o may win output o; 0: input o never wins output o
//   MODE_TDM     1: fixed rotating slots; 0: round-robin with wormhole lock
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req_i        [o*NPORTS+i] input i has a flit for output o
//   tail_i       [i] the current flit at input i is a tail flit
//   out_ready_i  [o] downstream of output o accepts a flit this cycle
//   grant_o      [o*NPORTS+i] input i owns output o (decoded from registers)
//   busy_o       [o] output o is locked to an owner
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
   parameter int NPORTS      = 5,
   parameter bit ALLOW_UTURN = 1'b0,
   parameter bit MODE_TDM    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS*NPORTS-1:0] req_i,
   input  logic [NPORTS-1:0]        tail_i,
   input  logic [NPORTS-1:0]        out_ready_i,
   output logic [NPORTS*NPORTS-1:0] grant_o,
   output logic [NPORTS-1:0]        busy_o
);

   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef logic [PW-1:0] idx_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Port index increment. The wrap from NPORTS-1 to 0 is explicit, so a
   // port count that is not a power of two still rotates correctly.
   function automatic idx_t idx_inc(input idx_t v);
      if (v == idx_t'(NPORTS - 1)) begin
         return '0;
      end
      return v + idx_t'(1);
   endfunction

   for (genvar o = 0; o < NPORTS; o++) begin : g_out

      // Request column for this output: bit i is set when input i wants output o.
      logic [NPORTS-1:0] req_row;
      logic [NPORTS-1:0] grant_row;

      assign req_row                      = req_i[o*NPORTS +: NPORTS];
      assign grant_o[o*NPORTS +: NPORTS] = grant_row;

      if (MODE_TDM) begin : g_tdm
         // ------------------------------------------------------------------
         // Legacy TDM: the slot owner gets the output every cycle whether it
         // has anything to send or not.
         // ------------------------------------------------------------------
         localparam int SLOT_RST = (o + 1) % NPORTS;

         idx_t slot_q;
         idx_t slot_d;
         logic unused_tdm_inputs;

         // Requests, tails and ready play no part in TDM arbitration.
         assign unused_tdm_inputs = ^{req_row, tail_i, out_ready_i};

         // NOTE: every variable written in always_comb gets a default at the
         // top. A path that leaves it unassigned would infer a latch.
         always_comb begin
            slot_d = idx_inc(slot_q);
            if (!ALLOW_UTURN && (slot_d == idx_t'(o))) begin
               slot_d = idx_inc(slot_d);
            end
         end

         // NOTE: the reset here is synchronous and active-high, so rst is
         // sampled inside the clocked block and is not in the sensitivity list.
         always_ff @(posedge clk) begin
            if (rst) begin
               slot_q <= idx_t'(SLOT_RST);
            end else begin
               slot_q <= slot_d;
            end
         end

         always_comb begin
            grant_row = '0;
            for (int i = 0; i < NPORTS; i++) begin
               grant_row[i] = (slot_q == idx_t'(i));
            end
         end

         assign busy_o[o] = 1'b0;

      end else begin : g_rr
         // ------------------------------------------------------------------
         // Round-robin with wormhole lock, one IDLE/LOCKED FSM per output.
         // ------------------------------------------------------------------
         state_t            state_q, state_d;
         idx_t              owner_q, owner_d;
         idx_t              ptr_q,   ptr_d;
         logic [NPORTS-1:0] elig;
         idx_t              winner;
         logic              any_elig;
         logic              owner_req;
         logic              owner_tail;
         logic              transfer;

         // An input may not win its own output unless U-turns are allowed.
         always_comb begin
            elig = req_row;
            if (!ALLOW_UTURN) begin
               elig[o] = 1'b0;
            end
         end

         // Priority scan starts at ptr+1 and ends at ptr. The first eligible
         // input in that order wins.
         // NOTE: the scan uses blocking assignments. cand and any_elig must take
         // their new values within the same iteration. The state registers
         // below use non-blocking assignments only.
         always_comb begin : scan
            idx_t cand;
            cand     = ptr_q;
            winner   = ptr_q;
            any_elig = 1'b0;
            for (int k = 0; k < NPORTS; k++) begin
               cand = idx_inc(cand);
               if (!any_elig && elig[cand]) begin
                  any_elig = 1'b1;
                  winner   = cand;
               end
            end
         end

         assign owner_req  = req_row[owner_q];
         assign owner_tail = tail_i[owner_q];
         assign transfer   = owner_req && out_ready_i[o];

         always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            case (state_q)
               ST_IDLE: begin
                  // Acquisition ignores out_ready_i. The grant can be taken
                  // while downstream is stalled.
                  if (any_elig) begin
                     state_d = ST_LOCKED;
                     owner_d = winner;
                  end
               end
               ST_LOCKED: begin
                  // The lock drops when the tail flit moves or the owner gives
                  // up. In both cases the scan then resumes just past the
                  // owner, so the owner has lowest priority next time.
                  if (!owner_req || (transfer && owner_tail)) begin
                     state_d = ST_IDLE;
                     ptr_d   = owner_q;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= ST_IDLE;
               owner_q <= '0;
               ptr_q   <= idx_t'(o);
            end else begin
               state_q <= state_d;
               owner_q <= owner_d;
               ptr_q   <= ptr_d;
            end
         end

         // The grant is decoded from registered state only, so no input has a
         // combinational path to the crossbar select.
         always_comb begin
            grant_row = '0;
            for (int i = 0; i < NPORTS; i++) begin
               grant_row[i] = (state_q == ST_LOCKED) && (owner_q == idx_t'(i));
            end
         end

         assign busy_o[o] = (state_q == ST_LOCKED);
      end
   end

endmodule
